// File: rtl/reg_dump_uart_if.sv
// Debug-dump bus: start request, core register read port and UART/status outputs.
interface reg_dump_uart_if;
  logic        start;
  logic [15:0] reg_out;
  logic [3:0]  reg_addr_d;
  logic        tx;
  logic        busy;
  logic        done;

  modport slave  (input start, reg_out, output reg_addr_d, tx, busy, done);
  modport master (output start, reg_out, input reg_addr_d, tx, busy, done);
endinterface

// File: rtl/reg_dump_uart.sv
// Streams a header byte and {index, hi, lo} for each core register over 8N1 UART.
module reg_dump_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 16
) (
  input logic            clk,
  input logic            rst,
  reg_dump_uart_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, SET_ADDR, SAMPLE, SEND_IDX, SEND_HI, SEND_LO} state_t;

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    addr_q, addr_d;
  logic [15:0]   snap_q, snap_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic [1:0]    sync_q, sync_d;
  logic [7:0]    tx_byte;
  logic [9:0]    frame;

  // Reset release is re-timed so start is only honoured two edges after rst rises.
  assign sync_d = {sync_q[0], 1'b1};

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    tx_byte = 8'hFF;
    frame   = 10'h3FF;

    case (state_q)
      IDLE: if (bus.start && sync_q[1]) begin
        state_d = HDR;
        baud_d  = '0;
        bit_d   = '0;
        idx_d   = '0;
      end
      SET_ADDR: state_d = SAMPLE;
      SAMPLE: begin
        snap_d  = bus.reg_out;
        state_d = SEND_IDX;
      end
      default: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = '0;
            case (state_q)
              HDR:      begin state_d = SET_ADDR; addr_d = '0; end
              SEND_IDX: state_d = SEND_HI;
              SEND_HI:  state_d = SEND_LO;
              default: if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                done_d  = 1'b1;
                addr_d  = '0;
              end else begin
                state_d = SET_ADDR;
                idx_d   = idx_q + 4'd1;
                addr_d  = idx_q + 4'd1;
              end
            endcase
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase

    // tx is registered from the next-state view so each bit appears on the edge that enters it.
    case (state_d)
      HDR:      tx_byte = 8'hA5;
      SEND_IDX: tx_byte = {4'h0, idx_d};
      SEND_HI:  tx_byte = snap_d[15:8];
      SEND_LO:  tx_byte = snap_d[7:0];
      default:  tx_byte = 8'hFF;
    endcase
    frame = {1'b1, tx_byte, 1'b0};
    if (state_d inside {HDR, SEND_IDX, SEND_HI, SEND_LO}) tx_d = frame[bit_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.reg_addr_d = addr_q;
endmodule

// File: tb/tb_reg_dump_uart.sv
// Randomized dump checks against a byte-stream model and a sampling UART receiver.
module tb_reg_dump_uart;
  localparam int C1 = 4, N1 = 16, C2 = 2, N2 = 1;
  localparam int TOT1 = (1 + 3*N1)*10*C1 + 2*N1;
  localparam int TOT2 = (1 + 3*N2)*10*C2 + 2*N2;

  logic clk = 1'b0;
  logic rst1, rst2;
  int   n_tests = 0, n_fail = 0;
  int   tim_err [2];

  logic [15:0] regs1 [16];
  logic [15:0] regs2 [16];
  logic [7:0]  rxq1 [$], rxq2 [$], expq1 [$], expq2 [$];

  reg_dump_uart_if bus1 ();
  reg_dump_uart_if bus2 ();

  reg_dump_uart #(.CLKS_PER_BIT(C1), .NUM_REGS(N1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  reg_dump_uart #(.CLKS_PER_BIT(C2), .NUM_REGS(N2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  always #5 clk = ~clk;

  assign bus1.reg_out = regs1[bus1.reg_addr_d];
  assign bus2.reg_out = regs2[bus2.reg_addr_d];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? bus1.tx : bus2.tx;
  endfunction

  function automatic logic get_rst(input int w);
    return (w == 0) ? rst1 : rst2;
  endfunction

  // Receiver: frame begins at the first low sample; every bit must stay flat for cpb samples.
  task automatic uart_rx(input int w, input int cpb);
    forever begin
      @(negedge clk);
      if (get_rst(w) === 1'b1 && get_tx(w) === 1'b0) begin
        logic [9:0] bits;
        bit ok, aborted;
        bits = '0; ok = 1'b1; aborted = 1'b0;
        for (int k = 1; k < 10*cpb; k++) begin
          @(negedge clk);
          if (get_rst(w) !== 1'b1) begin aborted = 1'b1; break; end
          if (k % cpb == 0) bits[k/cpb] = get_tx(w);
          else if (get_tx(w) !== bits[k/cpb]) ok = 1'b0;
        end
        if (!aborted) begin
          if (!ok || bits[9] !== 1'b1) tim_err[w]++;
          if (w == 0) rxq1.push_back(bits[8:1]); else rxq2.push_back(bits[8:1]);
        end
      end
    end
  endtask

  initial uart_rx(0, C1);
  initial uart_rx(1, C2);

  task automatic cmp_rx1();
    chk("rx_count", rxq1.size(), expq1.size());
    for (int i = 0; i < rxq1.size() && i < expq1.size(); i++) chk("rx_byte", rxq1[i], expq1[i]);
    chk("bit_timing", tim_err[0], 0);
  endtask

  task automatic clear1();
    rxq1.delete(); expq1.delete(); tim_err[0] = 0;
  endtask

  // One dump on dut1; expected stream is the header then {i, hi, lo} from the register file.
  task automatic run1(input bit spam, input bit mutate, input bit chained,
                      input bit chain_next, input int abort_at);
    int bc;
    expq1.push_back(8'hA5);
    for (int i = 0; i < N1; i++) begin
      expq1.push_back(8'(i));
      expq1.push_back(regs1[i][15:8]);
      expq1.push_back(regs1[i][7:0]);
    end
    if (!chained) begin @(negedge clk); bus1.start = 1'b1; end
    @(negedge clk);
    bus1.start = 1'b0;
    chk("start_tx_low", bus1.tx, 1'b0);
    chk("start_busy", bus1.busy, 1'b1);
    bc = 1;
    while (bc < 5000) begin
      @(negedge clk);
      if (!bus1.busy) break;
      bc++;
      if (spam) bus1.start = 1'($urandom % 2);
      if (mutate && bc == 464) regs1[3] = 16'hAB00;
      if (bc == abort_at) begin
        rst1 = 1'b0;
        #1;
        chk("abort_tx", bus1.tx, 1'b1);
        chk("abort_busy", bus1.busy, 1'b0);
        chk("abort_addr", bus1.reg_addr_d, 4'd0);
        chk("abort_done", bus1.done, 1'b0);
        bus1.start = 1'b0;
        return;
      end
    end
    bus1.start = chain_next;
    chk("busy_cycles", bc, TOT1);
    chk("done_pulse", bus1.done, 1'b1);
    chk("addr_idle", bus1.reg_addr_d, 4'd0);
    if (!chain_next) begin
      @(negedge clk);
      chk("done_one_cycle", bus1.done, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act, bc;
    tim_err[0] = 0; tim_err[1] = 0;
    rst1 = 1'b0; rst2 = 1'b0;
    bus1.start = 1'b0; bus2.start = 1'b0;
    for (int i = 0; i < 16; i++) begin regs1[i] = 16'($urandom); regs2[i] = 16'($urandom); end
    #22;
    chk("rst_tx", bus1.tx, 1'b1);
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_done", bus1.done, 1'b0);
    chk("rst_addr", bus1.reg_addr_d, 4'd0);
    @(negedge clk); rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);

    // Known pattern 0x1000+i.
    for (int i = 0; i < 16; i++) regs1[i] = 16'h1000 + 16'(i);
    clear1();
    run1(1'b0, 1'b0, 1'b0, 1'b0, 0);
    cmp_rx1();

    // Core write during SEND_HI of index 3 must not split the value.
    for (int i = 0; i < 16; i++) regs1[i] = 16'($urandom);
    regs1[3] = 16'h12FF;
    clear1();
    run1(1'b0, 1'b1, 1'b0, 1'b0, 0);
    cmp_rx1();

    // Start spam during a dump, then start held at done for a gapless second dump.
    for (int i = 0; i < 16; i++) regs1[i] = 16'($urandom);
    clear1();
    run1(1'b1, 1'b0, 1'b0, 1'b1, 0);
    run1(1'b0, 1'b0, 1'b1, 1'b0, 0);
    cmp_rx1();

    // Reset during data bit 4 of index 7's SEND_HI.
    clear1();
    run1(1'b0, 1'b0, 1'b0, 1'b0, 958);
    repeat (3) @(negedge clk);
    rst1 = 1'b1; bus1.start = 1'b1;
    @(negedge clk);
    chk("sync_release", bus1.busy, 1'b0);
    bus1.start = 1'b0;
    act = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.reg_addr_d !== 4'd0) act++;
    end
    chk("quiet_after_reset", act, 0);
    for (int i = 0; i < 16; i++) regs1[i] = 16'($urandom);
    clear1();
    run1(1'b0, 1'b0, 1'b0, 1'b0, 0);
    cmp_rx1();

    // Single register, two clocks per bit.
    regs2[0] = 16'($urandom);
    rxq2.delete(); expq2.delete(); tim_err[1] = 0;
    expq2.push_back(8'hA5); expq2.push_back(8'h00);
    expq2.push_back(regs2[0][15:8]); expq2.push_back(regs2[0][7:0]);
    @(negedge clk); bus2.start = 1'b1;
    @(negedge clk); bus2.start = 1'b0;
    chk("n1_start_tx", bus2.tx, 1'b0);
    bc = 1;
    while (bc < 1000) begin
      @(negedge clk);
      if (!bus2.busy) break;
      bc++;
    end
    chk("n1_busy_cycles", bc, TOT2);
    chk("n1_done", bus2.done, 1'b1);
    chk("n1_rx_count", rxq2.size(), expq2.size());
    for (int i = 0; i < rxq2.size() && i < expq2.size(); i++) chk("n1_rx_byte", rxq2[i], expq2[i]);
    chk("n1_bit_timing", tim_err[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_dump_uart.md
REG_DUMP_UART -- requirements
Module: reg_dump_uart

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL provide parameter NUM_REGS, default 16, number of registers dumped (legal range 1..16).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  dump request; sampled on the rising edge of clk.
REQ-006 SHALL have port reg_out  input  16  register read data from the core debug port.
REQ-007 SHALL have port reg_addr_d  output  4  register index presented to the core debug port.
REQ-008 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  high while a dump is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-011 SHALL implement the top states IDLE, HDR, SET_ADDR, SAMPLE, SEND_IDX, SEND_HI, SEND_LO.
REQ-012 SHALL leave IDLE only when start=1 at an edge; that edge SHALL enter HDR, set busy=1 and drive tx=0 (header start bit).
REQ-013 SHALL ignore start while busy=1; no request is queued.
REQ-014 SHALL transmit header byte 0xA5 in HDR, then run SET_ADDR -> SAMPLE -> SEND_IDX -> SEND_HI -> SEND_LO once per index 0..NUM_REGS-1, in ascending order.
REQ-015 SET_ADDR SHALL last 1 cycle and drive reg_addr_d = index; tx held 1.
REQ-016 SAMPLE SHALL last 1 cycle and capture reg_out into a 16-bit snapshot at its closing edge; tx held 1.
REQ-017 SEND_HI and SEND_LO SHALL send snapshot[15:8] and snapshot[7:0], so a core write during transmission never splits a value.
REQ-018 SEND_IDX SHALL send the byte {4'h0, index}.
REQ-019 Each byte frame SHALL be: start bit 0, data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles (10*CLKS_PER_BIT cycles per frame).
REQ-020 Consecutive frames within one register group, and HDR -> SET_ADDR, SHALL be back-to-back with no extra idle cycles.
REQ-021 reg_addr_d SHALL hold its value from SET_ADDR until the next SET_ADDR, and SHALL return to 0 on entering IDLE.
REQ-022 After the stop bit of SEND_LO for index NUM_REGS-1 SHALL: enter IDLE, busy=0, done=1 for exactly one cycle.
REQ-023 busy SHALL be high for exactly (1+3*NUM_REGS)*10*CLKS_PER_BIT + 2*NUM_REGS cycles per dump.
REQ-024 The baud counter SHALL be sized to hold CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary; the bit counter SHALL wrap 0..9 per frame.
REQ-025 start=1 in the same cycle that done=1 SHALL begin a new dump on that edge (back-to-back dumps allowed).

Reset
REQ-026 rst=0 SHALL immediately, without a clock edge, force: state IDLE, tx=1, busy=0, done=0, reg_addr_d=0, snapshot=0, all counters 0.
REQ-027 Reset mid-frame SHALL abort the dump; tx SHALL be high in the same cycle; after rst returns to 1, no output SHALL change until a new start.
REQ-028 Release of rst SHALL be synchronised internally so that no state leaves IDLE on the first edge after release.

Verification (CLKS_PER_BIT=4, NUM_REGS=16 unless noted)
REQ-029 Registers r[i]=0x1000+i, one-cycle start pulse -> UART decoder receives 49 bytes: A5, then 00 10 00, 01 10 01, ..., 0F 10 0F; busy high for 1992 cycles; one done pulse.
REQ-030 Check bit timing at tx: every bit lasts 4 cycles; tx falls on the edge that samples start; reg_addr_d steps 0..15, each held across SAMPLE.
REQ-031 Change reg_out from 0x12FF to 0xAB00 during the SEND_HI of index 3 -> bytes 03 12 FF are sent (snapshot consistency).
REQ-032 Pulse start repeatedly during a dump -> single 49-byte dump, single done; start held high at done -> second dump starts with no gap cycle.
REQ-033 rst=0 during data bit 4 of index 7's SEND_HI -> tx=1, busy=0, reg_addr_d=0 with no clock edge; no activity until the next start; the next dump is complete and correct.
REQ-034 NUM_REGS=1, CLKS_PER_BIT=2 -> bytes A5 00 hi lo; busy high for 82 cycles.
